// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX family of pipeline registers: default widths,
// the ID/EX payload record, the NOP encoding and the stall-counter geometry.
package pipe_pkg;

   localparam int DEF_ALUOP_W  = 8;
   localparam int DEF_ALUSEL_W = 3;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_RADDR_W  = 5;

   localparam int             STALL_W   = 16;
   localparam logic [15:0]    STALL_MAX = 16'hFFFF;

   // Field order here is also the bit order of the flattened payload vector.
   typedef struct packed {
      logic [DEF_ALUOP_W-1:0]  aluop;
      logic [DEF_ALUSEL_W-1:0] alusel;
      logic [DEF_DATA_W-1:0]   reg1;
      logic [DEF_DATA_W-1:0]   reg2;
      logic [DEF_RADDR_W-1:0]  wd;
      logic                    wreg;
   } id_ex_t;

   localparam logic [DEF_ALUOP_W-1:0]  NOP_ALUOP  = '0;
   localparam logic [DEF_ALUSEL_W-1:0] NOP_ALUSEL = '0;
   localparam logic [DEF_DATA_W-1:0]   NOP_REG1   = '0;
   localparam logic [DEF_DATA_W-1:0]   NOP_REG2   = '0;
   localparam logic [DEF_RADDR_W-1:0]  NOP_WD     = '0;
   localparam logic                    NOP_WREG   = 1'b0;

   localparam id_ex_t NOP_ID_EX = '{
      aluop:  NOP_ALUOP,
      alusel: NOP_ALUSEL,
      reg1:   NOP_REG1,
      reg2:   NOP_REG2,
      wd:     NOP_WD,
      wreg:   NOP_WREG
   };

   function automatic int payload_width(input int aluop_w, input int alusel_w,
                                        input int data_w, input int raddr_w);
      return aluop_w + alusel_w + 2 * data_w + raddr_w + 1;
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready buffer (main + skid) with synchronous flush.
// in_ready is registered, so there is no combinational path from out_ready to in_ready.
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid, main_valid_d;
   logic         skid_valid, skid_valid_d;
   logic [W-1:0] main_data, main_data_d;
   logic [W-1:0] skid_data, skid_data_d;
   logic         rdy_q;
   logic         in_xfer, out_xfer;

   // Held low during reset; the register itself resets to 1 so the first
   // edge after reset release can already accept.
   assign in_ready  = rdy_q & ~rst;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = main_valid & out_ready;
   assign out_valid = main_valid;
   assign out_data  = main_data;

   always_comb begin
      main_valid_d = main_valid;
      skid_valid_d = skid_valid;
      main_data_d  = main_data;
      skid_data_d  = skid_data;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_xfer) begin
         // in_ready is low whenever skid is full, so in_xfer cannot coincide here.
         if (skid_valid) begin
            main_data_d  = skid_data;
            skid_valid_d = 1'b0;
         end else if (in_xfer) begin
            main_data_d = in_data;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_xfer) begin
         if (main_valid) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end else begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
         rdy_q      <= 1'b1;
      end else begin
         main_valid <= main_valid_d;
         skid_valid <= skid_valid_d;
         main_data  <= main_data_d;
         skid_data  <= skid_data_d;
         rdy_q      <= ~skid_valid_d;
      end
   end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid/ready handshake, flush and a saturating stall counter.
// Define ID_EX_SKID_EN for a two-entry skid buffer (registered in_ready); default is one entry.
module id_ex_pipe
   import pipe_pkg::*;
#(
   parameter int ALUOP_W  = DEF_ALUOP_W,
   parameter int ALUSEL_W = DEF_ALUSEL_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int RADDR_W  = DEF_RADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                clr_cnt,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ALUOP_W-1:0]  in_aluop,
   input  logic [ALUSEL_W-1:0] in_alusel,
   input  logic [DATA_W-1:0]   in_reg1,
   input  logic [DATA_W-1:0]   in_reg2,
   input  logic [RADDR_W-1:0]  in_wd,
   input  logic                in_wreg,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ALUOP_W-1:0]  out_aluop,
   output logic [ALUSEL_W-1:0] out_alusel,
   output logic [DATA_W-1:0]   out_reg1,
   output logic [DATA_W-1:0]   out_reg2,
   output logic [RADDR_W-1:0]  out_wd,
   output logic                out_wreg,
   output logic [15:0]         stall_cnt
);

   localparam int PAY_W = payload_width(ALUOP_W, ALUSEL_W, DATA_W, RADDR_W);

   localparam logic [PAY_W-1:0] NOP_PAY = {
      ALUOP_W'(NOP_ALUOP), ALUSEL_W'(NOP_ALUSEL), DATA_W'(NOP_REG1),
      DATA_W'(NOP_REG2), RADDR_W'(NOP_WD), NOP_WREG
   };

   logic [PAY_W-1:0]   in_pay;
   logic [PAY_W-1:0]   held_pay;
   logic [PAY_W-1:0]   out_pay;
   logic               held_valid;
   logic [STALL_W-1:0] stall_q;

   assign in_pay = {in_aluop, in_alusel, in_reg1, in_reg2, in_wd, in_wreg};

`ifdef ID_EX_SKID_EN
   pipe_skid_buf #(
      .W(PAY_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_pay),
      .out_valid (held_valid),
      .out_ready (out_ready),
      .out_data  (held_pay)
   );
`else
   logic in_xfer;
   logic out_xfer;

   // Single entry: accept when empty or when the held payload leaves this edge.
   assign in_ready = ~rst & (~held_valid | out_ready);
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = held_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_valid <= 1'b0;
         held_pay   <= NOP_PAY;
      end else if (flush) begin
         held_valid <= 1'b0;
         held_pay   <= NOP_PAY;
      end else if (in_xfer) begin
         held_valid <= 1'b1;
         held_pay   <= in_pay;
      end else if (out_xfer) begin
         held_valid <= 1'b0;
         held_pay   <= NOP_PAY;
      end
   end
`endif

   // EX must never see stale operands on a bubble.
   assign out_pay   = held_valid ? held_pay : NOP_PAY;
   assign out_valid = held_valid;
   assign {out_aluop, out_alusel, out_reg1, out_reg2, out_wd, out_wreg} = out_pay;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (clr_cnt) begin
         stall_q <= '0;
      end else if (held_valid && !out_ready && stall_q != STALL_MAX) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed scenarios plus a randomized run, all checked by a
// queue-based scoreboard of the payloads the stage should be holding.
`timescale 1ns/1ps
module tb_id_ex_pipe;
   import pipe_pkg::*;

   localparam int PW = $bits(id_ex_t);
`ifdef ID_EX_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        clk;
   logic        rst, flush, clr_cnt;
   logic        in_valid, in_ready;
   logic        out_valid, out_ready;
   id_ex_t      in_p;
   logic [7:0]  out_aluop;
   logic [2:0]  out_alusel;
   logic [31:0] out_reg1, out_reg2;
   logic [4:0]  out_wd;
   logic        out_wreg;
   logic [15:0] stall_cnt;
   logic [PW-1:0] out_flat;

   logic [PW-1:0] exp_q[$];
   int exp_cnt;
   int n_checks;
   int n_errors;

   assign out_flat = {out_aluop, out_alusel, out_reg1, out_reg2, out_wd, out_wreg};

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   id_ex_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .clr_cnt    (clr_cnt),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_aluop   (in_p.aluop),
      .in_alusel  (in_p.alusel),
      .in_reg1    (in_p.reg1),
      .in_reg2    (in_p.reg2),
      .in_wd      (in_p.wd),
      .in_wreg    (in_p.wreg),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_aluop  (out_aluop),
      .out_alusel (out_alusel),
      .out_reg1   (out_reg1),
      .out_reg2   (out_reg2),
      .out_wd     (out_wd),
      .out_wreg   (out_wreg),
      .stall_cnt  (stall_cnt)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic id_ex_t mk(input logic [31:0] r1);
      id_ex_t p;
      p.aluop  = 8'($urandom);
      p.alusel = 3'($urandom);
      p.reg1   = r1;
      p.reg2   = $urandom;
      p.wd     = 5'($urandom);
      p.wreg   = 1'($urandom);
      return p;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   // exp_q holds, oldest first, every payload the stage should currently be holding.
   always @(negedge clk) begin : scoreboard
      logic [PW-1:0] front;
      logic exp_rdy, in_x, out_x;
      if (rst) begin
         exp_q.delete();
         exp_cnt = 0;
      end
      front = (exp_q.size() > 0) ? exp_q[0] : NOP_ID_EX;
      exp_rdy = !rst && (SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || out_ready));
      check("sb_out_valid", out_valid, exp_q.size() > 0);
      check("sb_payload", out_flat, front);
      check("sb_in_ready", in_ready, exp_rdy);
      check("sb_stall_cnt", stall_cnt, exp_cnt[15:0]);
      in_x  = in_valid && exp_rdy;
      out_x = (exp_q.size() > 0) && out_ready;
      if (!rst) begin
         if (exp_q.size() > 0 && !out_ready && exp_cnt < 65535) exp_cnt++;
         if (clr_cnt) exp_cnt = 0;
         if (flush) begin
            exp_q.delete();
         end else begin
            if (out_x) void'(exp_q.pop_front());
            if (in_x) exp_q.push_back(in_p);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : main
      id_ex_t pa, pb;
      logic b_acc;
      int vp, rp;
      n_checks = 0;
      n_errors = 0;
      exp_cnt  = 0;

      // Reset with a payload offered: nothing may get in.
      rst = 1'b1; flush = 1'b0; clr_cnt = 1'b0;
      in_valid = 1'b1; in_p = mk(32'h0); in_p.aluop = 8'h21; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rst_out_valid", out_valid, 1'b0);
         check("rst_out_nop", out_flat, NOP_ID_EX);
         check("rst_stall_cnt", stall_cnt, 16'h0);
         check("rst_in_ready", in_ready, 1'b0);
      end

      // Streaming 1..4 with one-cycle latency.
      rst = 1'b0;
      in_p = mk(32'd1);
      for (int k = 2; k <= 4; k++) begin
         tick();
         in_p = mk(32'(k));
         #1;
         check("stream_reg1", out_reg1, 32'(k - 1));
         check("stream_valid", out_valid, 1'b1);
         check("stream_in_ready", in_ready, 1'b1);
      end
      tick();
      in_valid = 1'b0;
      #1;
      check("stream_reg1_last", out_reg1, 32'd4);
      tick();
      check("stream_drained", out_valid, 1'b0);

      // Async reset while a payload is held.
      in_valid = 1'b1; in_p = mk(32'h77); out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", out_valid, 1'b0);
      check("async_rst_nop", out_flat, NOP_ID_EX);
      check("async_rst_cnt", stall_cnt, 16'h0);
      tick();
      rst = 1'b0; in_valid = 1'b1; in_p = mk(32'hE); out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("post_rst_accept", out_reg1, 32'hE);
      tick();

      // Back-pressure: A then B offered while out_ready is low.
      pa = mk(32'hA); pb = mk(32'hB);
      in_valid = 1'b1; in_p = pa; out_ready = 1'b0;
      tick();
      in_p = pb;
      #1;
      check("bp_holds_a", out_reg1, 32'hA);
      b_acc = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (in_valid && in_ready) b_acc = 1'b1;
         tick();
         if (b_acc) in_valid = 1'b0;
      end
      #1;
      check("bp_stall_cnt", stall_cnt, 16'd5);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_b_accepted", b_acc, SKID);
      check("bp_still_a", out_reg1, 32'hA);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      check("bp_b_next", out_reg1, 32'hB);
      check("bp_b_valid", out_valid, 1'b1);
      tick();
      check("bp_drained", out_valid, 1'b0);

      // Flush with C offered: stage empties, C lost, counter untouched.
      clr_cnt = 1'b1; in_valid = 1'b1; in_p = mk(32'hA); out_ready = 1'b0;
      tick();
      clr_cnt = 1'b0; in_valid = SKID; in_p = mk(32'hB);
      tick();
      in_valid = 1'b1; in_p = mk(32'hC); flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      check("flush_valid", out_valid, 1'b0);
      check("flush_nop", out_flat, NOP_ID_EX);
      check("flush_cnt", stall_cnt, 16'd2);
      tick();
      check("flush_c_absent", out_valid, 1'b0);
      check("flush_cnt_hold", stall_cnt, 16'd2);
      // Flush must also kill an in transfer the stage was ready for.
      out_ready = 1'b1; in_valid = 1'b1; in_p = mk(32'hD); flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_kills_in", out_valid, 1'b0);

      // Counter saturation and clear.
      clr_cnt = 1'b1; in_valid = 1'b1; in_p = mk(32'h5); out_ready = 1'b0;
      tick();
      clr_cnt = 1'b0; in_valid = 1'b0;
      repeat (65534) tick();
      check("cnt_fffe", stall_cnt, 16'hFFFE);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("cnt_saturate", stall_cnt, 16'hFFFF);
      end
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      check("cnt_clear", stall_cnt, 16'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // Randomized traffic with occasional flush, clear and reset.
      vp = 50; rp = 50;
      for (int c = 0; c < 10000; c++) begin
         if (c % 500 == 0) begin
            vp = $urandom_range(10, 100);
            rp = $urandom_range(10, 100);
         end
         in_valid  = ($urandom_range(1, 100) <= vp);
         out_ready = ($urandom_range(1, 100) <= rp);
         in_p      = mk($urandom);
         flush     = ($urandom_range(0, 63) == 0);
         clr_cnt   = ($urandom_range(0, 127) == 0);
         if (rst) rst = 1'($urandom_range(0, 1));
         else     rst = ($urandom_range(0, 999) == 0);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
      repeat (4) tick();
      check("final_empty", out_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
